// File: rtl/dmem_dma_pkg.sv
// dmem_dma_pkg: shared types and constants for the data-memory block-transfer engine.
package dmem_dma_pkg;

  // Used memory address bits and data word width
  localparam int ADDR_W = 16;
  localparam int WORD_W = 32;

  // Command op codes
  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  // Transfer engine states
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    FILL,
    DONE,
    ABRT
  } state_t;

endpackage

// File: rtl/dmem_dma_csum.sv
// dmem_dma_csum: 32-bit wrap-around accumulator of every word the engine writes.
// Only instantiated when DMEM_DMA_CHECKSUM_EN is defined.
module dmem_dma_csum
  import dmem_dma_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              add,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] sum
);

  logic [WORD_W-1:0] sum_reg;

  // Clear on command accept, otherwise add each written word; holds when idle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_reg <= '0;
    end else if (clear) begin
      sum_reg <= '0;
    end else if (add) begin
      sum_reg <= sum_reg + data;
    end
  end

  assign sum = sum_reg;

endmodule

// File: rtl/dmem_dma.sv
// dmem_dma: copy/fill block-transfer initiator for the 64K-word data memory.
// Copies take two cycles per word (RD presents the source, WR forwards the
// memory's registered read data to the destination); fills write one word
// per cycle. Optional checksum accumulator: define DMEM_DMA_CHECKSUM_EN.
module dmem_dma
  import dmem_dma_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] length,
  input  logic [31:0] fill_value,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [15:0] words_done,
  output logic [31:0] checksum,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t            state_reg;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [15:0]       remaining_reg;
  logic [WORD_W-1:0] fill_reg;
  logic [15:0]       words_done_reg;
  logic              write_active;
  logic              accept;

  // Upper address bits of the command are outside the memory and ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[31:ADDR_W], dst_addr[31:ADDR_W]};

  assign accept       = (state_reg == IDLE) && start;
  assign write_active = (state_reg == WR) || (state_reg == FILL);

  // Command sequencer: latches the command, walks addresses (mod 2^16) and counts words
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      remaining_reg  <= '0;
      fill_reg       <= '0;
      words_done_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            src_reg        <= src_addr[ADDR_W-1:0];
            dst_reg        <= dst_addr[ADDR_W-1:0];
            remaining_reg  <= length;
            fill_reg       <= fill_value;
            words_done_reg <= '0;
            if (length == 16'd0) begin
              state_reg <= DONE;
            end else if (op == OP_COPY) begin
              state_reg <= RD;
            end else begin
              state_reg <= FILL;
            end
          end
        end
        RD: begin
          state_reg <= abort ? ABRT : WR;
        end
        WR: begin
          // The write driven this cycle always lands, even when aborting
          src_reg        <= src_reg + ADDR_W'(1);
          dst_reg        <= dst_reg + ADDR_W'(1);
          words_done_reg <= words_done_reg + 16'd1;
          remaining_reg  <= remaining_reg - 16'd1;
          if (abort) begin
            state_reg <= ABRT;
          end else if (remaining_reg == 16'd1) begin
            state_reg <= DONE;
          end else begin
            state_reg <= RD;
          end
        end
        FILL: begin
          dst_reg        <= dst_reg + ADDR_W'(1);
          words_done_reg <= words_done_reg + 16'd1;
          remaining_reg  <= remaining_reg - 16'd1;
          if (abort) begin
            state_reg <= ABRT;
          end else if (remaining_reg == 16'd1) begin
            state_reg <= DONE;
          end else begin
            state_reg <= FILL;
          end
        end
        DONE:    state_reg <= IDLE;
        ABRT:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Memory port and status decode from registered state; in WR the memory's
  // own registered read data is forwarded so a copy costs two cycles per word
  always_comb begin
    busy      = (state_reg != IDLE);
    done      = (state_reg == DONE);
    aborted   = (state_reg == ABRT);
    mem_write = write_active;
    mem_read  = (state_reg == RD);
    mem_addr  = {{(32-ADDR_W){1'b0}}, (write_active ? dst_reg : src_reg)};
    mem_wdata = '0;
    if (state_reg == WR) begin
      mem_wdata = mem_rdata;
    end else if (state_reg == FILL) begin
      mem_wdata = fill_reg;
    end
  end

  assign words_done = words_done_reg;

`ifdef DMEM_DMA_CHECKSUM_EN
  dmem_dma_csum u_csum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept),
    .add     (mem_write),
    .data    (mem_wdata),
    .sum     (checksum)
  );
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign checksum      = '0;
`endif

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: table-driven and randomized checks of dmem_dma against a
// word-level model of copy/fill/abort (expected writes, timing, counts).
module tb_dmem_dma;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] length;
  logic [31:0] fill_value;
  logic        abort;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] words_done;
  logic [31:0] checksum;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks;
  int failures;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  dmem_dma dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .words_done (words_done),
    .checksum   (checksum),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory with registered read
  always @(posedge clock) begin
    if (mem_write) mem[mem_addr[15:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[15:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Outcome of a command from the word-level rules: active cycles, abort point
  function automatic void model_outcome(input logic op_i, input int len_i, input int abort_c,
                                        output int words, output int end_c, output bit ab);
    int active;
    active = op_i ? len_i : 2 * len_i;
    if (abort_c >= 1 && abort_c <= active) begin
      ab    = 1'b1;
      end_c = abort_c + 1;
      words = op_i ? abort_c : abort_c / 2;
    end else begin
      ab    = 1'b0;
      end_c = active + 1;
      words = len_i;
    end
  endfunction

  task automatic run_cmd(input string nm, input logic op_i, input logic [31:0] src_i,
                         input logic [31:0] dst_i, input logic [15:0] len_i,
                         input logic [31:0] fill_i, input int abort_c, input bit poke,
                         input int exp_words, input int exp_end, input bit exp_ab,
                         input bit chk_c, input logic [31:0] exp_c);
    logic [15:0] qa[$];
    logic [31:0] qd[$];
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] sum;
    logic [31:0] csum_exp;
    int end_c, done_cnt, ab_cnt, nw, viol, busy_viol, limit;
    bit exp_rd, exp_wr;

    // Expected write stream: forward word-by-word copy (overlap replicates) or fill
    sum = '0;
    for (int i = 0; i < exp_words; i++) begin
      a = dst_i[15:0] + 16'(i);
      d = op_i ? fill_i : ref_mem[16'(src_i[15:0] + 16'(i))];
      ref_mem[a] = d;
      qa.push_back(a);
      qd.push_back(d);
      sum += d;
    end

    end_c = 0; done_cnt = 0; ab_cnt = 0; nw = 0; viol = 0; busy_viol = 0;
    limit = 2 * int'(len_i) + 10;

    @(negedge clock);
    start = 1'b1; op = op_i; src_addr = src_i; dst_addr = dst_i;
    length = len_i; fill_value = fill_i; abort = 1'b0;
    @(posedge clock);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
      if (done) begin done_cnt++; if (end_c == 0) end_c = c; end
      if (aborted) begin ab_cnt++; if (end_c == 0) end_c = c; end
      if (busy !== ((end_c == 0) || (c == end_c))) busy_viol++;
      exp_rd = (op_i == 1'b0) && (c % 2 == 1) && (c < exp_end);
      exp_wr = (c < exp_end) && ((op_i == 1'b1) || (c % 2 == 0));
      if (mem_read !== exp_rd || mem_write !== exp_wr) viol++;
      if (mem_addr[31:16] !== 16'h0) viol++;
      if (mem_write === 1'b1) begin
        nw++;
        if (qa.size() > 0) begin
          chk({nm, "_waddr"}, {16'h0, mem_addr[15:0]}, {16'h0, qa.pop_front()});
          chk({nm, "_wdata"}, mem_wdata, qd.pop_front());
        end
      end else if (mem_wdata !== 32'h0) begin
        viol++;
      end
      start = poke && (c == 2);
      if (start) begin
        op = ~op_i; src_addr = 32'h1234; dst_addr = 32'h4321;
        length = 16'd7; fill_value = 32'hBAD0BAD0;
      end
      abort = (c == abort_c);
      if (end_c != 0 && c > end_c) break;
    end
    start = 1'b0;
    abort = 1'b0;

`ifdef DMEM_DMA_CHECKSUM_EN
    csum_exp = chk_c ? exp_c : sum;
`else
    csum_exp = 32'h0;
`endif
    chk({nm, "_end_cycle"}, 32'(end_c), 32'(exp_end));
    chk({nm, "_aborted"}, 32'(ab_cnt), exp_ab ? 32'd1 : 32'd0);
    chk({nm, "_done"}, 32'(done_cnt), exp_ab ? 32'd0 : 32'd1);
    chk({nm, "_writes"}, 32'(nw), 32'(exp_words));
    chk({nm, "_words_done"}, {16'h0, words_done}, 32'(exp_words));
    chk({nm, "_checksum"}, checksum, csum_exp);
    chk({nm, "_bus"}, 32'(viol), 32'd0);
    chk({nm, "_busy"}, 32'(busy_viol), 32'd0);
    $display("cmd %s op=%0d src=%04h dst=%04h len=%0d abort_c=%0d end=%0d words=%0d csum=%08h",
             nm, op_i, src_i[15:0], dst_i[15:0], len_i, abort_c, end_c, words_done, checksum);
  endtask

  typedef struct {
    string       nm;
    logic        op;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] fill;
    int          abort_c;
    bit          poke;
    int          exp_words;
    int          exp_end;
    bit          exp_ab;
    bit          chk_c;
    logic [31:0] exp_c;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic        r_op;
    logic [31:0] r_src, r_dst, r_fill, v;
    logic [15:0] r_len;
    int          r_ab, w, e;
    bit          ab;

    checks = 0; failures = 0;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0; abort = 1'b0;

    for (int i = 0; i < 65536; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[0] = 32'd20123; mem[1] = 32'd18833; mem[2] = 32'd39041;
    ref_mem[0] = 32'd20123; ref_mem[1] = 32'd18833; ref_mem[2] = 32'd39041;

    repeat (3) @(negedge clock);
    chk("reset_flags", {27'h0, busy, done, aborted, mem_write, mem_read}, 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_words", {16'h0, words_done}, 32'h0);
    chk("reset_csum", checksum, 32'h0);
    reset_n = 1'b1;

    vecs[0] = '{"copy3", 1'b0, 32'd0, 32'd100, 16'd3, 32'h0, 0, 1'b0, 3, 7, 1'b0, 1'b1, 32'd77997};
    vecs[1] = '{"fill4", 1'b1, 32'd0, 32'd200, 16'd4, 32'hDEADBEEF, 0, 1'b0, 4, 5, 1'b0, 1'b1, 32'h7AB6FBBC};
    vecs[2] = '{"len0", 1'b0, 32'd5, 32'd900, 16'd0, 32'h0, 0, 1'b0, 0, 1, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{"fillwrap", 1'b1, 32'd0, 32'h0000FFFF, 16'd2, 32'h12345678, 0, 1'b0, 2, 3, 1'b0, 1'b1, 32'h2468ACF0};
    vecs[4] = '{"copyabort", 1'b0, 32'd10, 32'd400, 16'd10, 32'h0, 6, 1'b0, 3, 7, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{"fillpoke", 1'b1, 32'd0, 32'd500, 16'd5, 32'hA5A5A5A5, 0, 1'b1, 5, 6, 1'b0, 1'b1, 32'h3C3C3C39};
    vecs[6] = '{"overlap", 1'b0, 32'd600, 32'd601, 16'd4, 32'h0, 0, 1'b0, 4, 9, 1'b0, 1'b0, 32'h0};

    for (int k = 0; k < 7; k++) begin
      run_cmd(vecs[k].nm, vecs[k].op, vecs[k].src, vecs[k].dst, vecs[k].len, vecs[k].fill,
              vecs[k].abort_c, vecs[k].poke, vecs[k].exp_words, vecs[k].exp_end,
              vecs[k].exp_ab, vecs[k].chk_c, vecs[k].exp_c);
    end
    chk("copy3_mem100", mem[100], 32'd20123);
    chk("copy3_mem102", mem[102], 32'd39041);
    chk("wrap_memFFFF", mem[16'hFFFF], 32'h12345678);
    chk("wrap_mem0000", mem[0], 32'h12345678);
    chk("overlap_mem604", mem[604], ref_mem[600]);

    // Reset in the middle of a fill: outputs clear at once, written words stay
    v = mem[302];
    @(negedge clock);
    start = 1'b1; op = 1'b1; dst_addr = 32'd300; length = 16'd8; fill_value = 32'hCAFEF00D;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_flags", {27'h0, busy, done, aborted, mem_write, mem_read}, 32'h0);
    chk("rst_mid_addr", mem_addr, 32'h0);
    chk("rst_mid_wdata", mem_wdata, 32'h0);
    chk("rst_mid_words", {16'h0, words_done}, 32'h0);
    chk("rst_mid_csum", checksum, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("rst_mid_mem300", mem[300], 32'hCAFEF00D);
    chk("rst_mid_mem301", mem[301], 32'hCAFEF00D);
    chk("rst_mid_mem302", mem[302], v);
    ref_mem[300] = 32'hCAFEF00D;
    ref_mem[301] = 32'hCAFEF00D;
    $display("cmd rst_mid fill dst=012c interrupted after 2 writes");
    run_cmd("after_rst", 1'b0, 32'd300, 32'd302, 16'd3, 32'h0, 0, 1'b0, 3, 7, 1'b0, 1'b0, 32'h0);

    // Randomized commands, including wrap-around addresses and random abort points
    for (int n = 0; n < 24; n++) begin
      r_op   = 1'($urandom % 2);
      r_src  = ($urandom % 4 == 0) ? 32'hFFF0 + ($urandom % 16) : $urandom;
      r_dst  = ($urandom % 4 == 0) ? 32'hFFF0 + ($urandom % 16) : $urandom;
      r_len  = 16'($urandom_range(0, 24));
      r_fill = $urandom;
      r_ab   = ($urandom % 3 == 0) ? int'($urandom_range(1, 2 * int'(r_len) + 2)) : 0;
      model_outcome(r_op, int'(r_len), r_ab, w, e, ab);
      run_cmd($sformatf("rand%0d", n), r_op, r_src, r_dst, r_len, r_fill, r_ab, 1'b0,
              w, e, ab, 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
